// File: rtl/shift2.sv
// Left-shift-by-2 for branch/jump address formation, with a
// combinational result and a registered valid-qualified copy.
module shift2 #(
   parameter int width_in  = 32,
   parameter int width_out = 32
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [width_in-1:0]  in,
   input  logic                 in_valid,
   output logic [width_out-1:0] out,
   output logic                 lost,
   output logic [width_out-1:0] out_q,
   output logic                 lost_q,
   output logic                 out_valid
);

   logic [width_in-1:0] s;

   assign s = {in[width_in-3:0], 2'b00};

   // Sized cast zero-extends or truncates to the output width.
   assign out  = width_out'(s);
   assign lost = in[width_in-1] | in[width_in-2];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         out_q     <= '0;
         lost_q    <= 1'b0;
         out_valid <= 1'b0;
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            out_q  <= out;
            lost_q <= lost;
         end
      end
   end

endmodule

// File: tb/tb_shift2.sv
// Bench for shift2: table-driven combinational vectors on three
// width configurations plus a scoreboard on the registered path.
module tb_shift2;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;

   logic [31:0] in32;
   logic [31:0] out32, out32_q;
   logic        lost32, lost32_q, vld32;

   logic [25:0] in26;
   logic [27:0] out28, out28_q;
   logic        lost26, lost26_q, vld26;

   logic [31:0] in16;
   logic [15:0] out16, out16_q;
   logic        lost16, lost16_q, vld16;

   int errors = 0;
   int checks = 0;

   shift2 u32 (
      .clk(clk), .reset_n(reset_n), .in(in32), .in_valid(in_valid),
      .out(out32), .lost(lost32), .out_q(out32_q),
      .lost_q(lost32_q), .out_valid(vld32)
   );

   shift2 #(.width_in(26), .width_out(28)) u26 (
      .clk(clk), .reset_n(reset_n), .in(in26), .in_valid(in_valid),
      .out(out28), .lost(lost26), .out_q(out28_q),
      .lost_q(lost26_q), .out_valid(vld26)
   );

   shift2 #(.width_in(32), .width_out(16)) u16 (
      .clk(clk), .reset_n(reset_n), .in(in16), .in_valid(in_valid),
      .out(out16), .lost(lost16), .out_q(out16_q),
      .lost_q(lost16_q), .out_valid(vld16)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish, got running want done");
      $fatal(1, "timeout");
   end

   typedef struct packed {
      logic [1:0]  sel;
      logic [31:0] in;
      logic [31:0] exp;
      logic        lost;
   } vec_t;

   typedef struct packed {
      logic [31:0] o;
      logic        l;
   } exp_t;

   vec_t        tbl [16];
   exp_t        sbq [$];
   logic [31:0] hold_o;
   logic        hold_l;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   // One clock of registered-path traffic on the 32/32 instance.
   task automatic cycle(input logic v, input logic [31:0] d,
                        input logic rn);
      exp_t e;
      logic ev;
      @(negedge clk);
      in32     = d;
      in_valid = v;
      reset_n  = rn;
      #1;
      chk("comb_out", out32, d << 2);
      chk("comb_lost", {31'd0, lost32}, {31'd0, |d[31:30]});
      ev = rn & v;
      if (ev) sbq.push_back('{o: d << 2, l: |d[31:30]});
      if (!rn) begin
         hold_o = '0;
         hold_l = 1'b0;
      end
      @(posedge clk);
      #1;
      chk("out_valid", {31'd0, vld32}, {31'd0, ev});
      if (ev) begin
         if (sbq.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
         end else begin
            e = sbq.pop_front();
            chk("out_q", out32_q, e.o);
            chk("lost_q", {31'd0, lost32_q}, {31'd0, e.l});
            hold_o = e.o;
            hold_l = e.l;
         end
      end else begin
         chk("out_q_hold", out32_q, hold_o);
         chk("lost_q_hold", {31'd0, lost32_q}, {31'd0, hold_l});
      end
   endtask

   initial begin
      reset_n  = 1'b0;
      in_valid = 1'b0;
      in32     = '0;
      in26     = '0;
      in16     = '0;
      hold_o   = '0;
      hold_l   = 1'b0;

      tbl[0]  = '{2'd0, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[1]  = '{2'd0, 32'h0000_000A, 32'h0000_0028, 1'b0};
      tbl[2]  = '{2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 1'b1};
      tbl[3]  = '{2'd0, 32'h4000_0000, 32'h0000_0000, 1'b1};
      tbl[4]  = '{2'd0, 32'h2000_0000, 32'h8000_0000, 1'b0};
      tbl[5]  = '{2'd0, 32'h1234_5678, 32'h48D1_59E0, 1'b0};
      tbl[6]  = '{2'd1, 32'h0000_0000, 32'h0000_0000, 1'b0};
      tbl[7]  = '{2'd1, 32'h0000_000A, 32'h0000_0028, 1'b0};
      tbl[8]  = '{2'd1, 32'h03FF_FFFF, 32'h03FF_FFFC, 1'b1};
      tbl[9]  = '{2'd1, 32'h0200_0000, 32'h0000_0000, 1'b1};
      tbl[10] = '{2'd1, 32'h0100_0000, 32'h0000_0000, 1'b1};
      tbl[11] = '{2'd1, 32'h00FF_FFFF, 32'h03FF_FFFC, 1'b0};
      tbl[12] = '{2'd2, 32'h0001_2345, 32'h0000_8D14, 1'b0};
      tbl[13] = '{2'd2, 32'hC000_0001, 32'h0000_0004, 1'b1};
      tbl[14] = '{2'd2, 32'h0000_FFFF, 32'h0000_FFFC, 1'b0};
      tbl[15] = '{2'd2, 32'h8000_4000, 32'h0000_0000, 1'b1};

      // Reset edge clears the registered path.
      cycle(1'b0, 32'h0, 1'b0);
      chk("rst_out_q28", {4'd0, out28_q}, 32'd0);
      chk("rst_vld26", {31'd0, vld26}, 32'd0);

      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         reset_n  = 1'b1;
         in_valid = 1'b0;
         in32 = tbl[i].in;
         in26 = tbl[i].in[25:0];
         in16 = tbl[i].in;
         #1;
         unique case (tbl[i].sel)
            2'd0: begin
               chk("tbl_out32", out32, tbl[i].exp);
               chk("tbl_lost32", {31'd0, lost32}, {31'd0, tbl[i].lost});
            end
            2'd1: begin
               chk("tbl_out28", {4'd0, out28}, tbl[i].exp);
               chk("tbl_lost26", {31'd0, lost26}, {31'd0, tbl[i].lost});
            end
            default: begin
               chk("tbl_out16", {16'd0, out16}, tbl[i].exp);
               chk("tbl_lost16", {31'd0, lost16}, {31'd0, tbl[i].lost});
            end
         endcase
      end

      // 26/28 registered capture of in=10.
      @(negedge clk);
      in26 = 26'd10;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk("out28_q", {4'd0, out28_q}, 32'd40);
      chk("vld26", {31'd0, vld26}, 32'd1);

      // Capture, hold with new input, then reset during valid.
      cycle(1'b1, 32'd10, 1'b1);
      cycle(1'b0, 32'd5, 1'b1);
      cycle(1'b1, 32'd10, 1'b0);
      chk("rst_lost_q", {31'd0, lost32_q}, 32'd0);
      cycle(1'b1, 32'hFFFF_FFFF, 1'b1);
      cycle(1'b0, 32'h0, 1'b1);

      // Back-to-back valids keep out_valid high each cycle.
      for (int i = 0; i < 20; i++)
         cycle(1'b1, $urandom, 1'b1);

      for (int i = 0; i < 60; i++)
         cycle(1'($urandom_range(0, 1)), $urandom,
               ($urandom_range(0, 9) != 0));

      @(negedge clk);
      in_valid = 1'b0;
      chk("sb_drained", sbq.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/shift2.md
Name: shift2

Overview:
- Parameterised left-shift-by-2 unit used in the MIPS datapath.
  - 32→32 for branch offsets (sign-extended immediate × 4).
  - 26→28 for jump targets (instruction index × 4).
- Provides a combinational result path plus a registered, valid-qualified copy for pipelined use.
- Flags input bits that are discarded by the shift.

Parameters:
- width_in, default 32: input word width; legal range ≥ 3.
- width_out, default 32: output word width; legal range ≥ 1.

Ports:
- clk  input  1  single system clock, rising-edge active.
- reset_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- in  input  width_in  operand to shift.
- in_valid  input  1  qualifies in for capture into the registered path.
- out  output  width_out  combinational shifted result.
- lost  output  1  combinational; high when in[width_in-1] or in[width_in-2] is 1.
- out_q  output  width_out  registered copy of out.
- lost_q  output  1  registered copy of lost.
- out_valid  output  1  high for one cycle when out_q/lost_q hold a freshly captured result.

Behaviour:
- Shift arithmetic, combinational, zero latency:
  - Form s = { in[width_in-3:0], 2'b00 }, width width_in; the top two bits of in are discarded.
  - If width_out ≥ width_in: out = s zero-extended, with upper (width_out − width_in) bits = 0.
  - If width_out < width_in: out = s[width_out-1:0], truncated.
  - out[1:0] is always 00.
  - Example: width_in=26, width_out=28, in=all ones → out = 28'b0011_1111_1111_1111_1111_1111_1100.
- out and lost depend only on in; they are unaffected by clk, reset_n or in_valid, including during reset.
- Registered path:
  - On a rising clk edge with reset_n=0: out_q ← 0, lost_q ← 0, out_valid ← 0.
  - On a rising clk edge with reset_n=1 and in_valid=1: out_q ← out, lost_q ← lost, out_valid ← 1. Latency is exactly 1 cycle.
  - On a rising clk edge with reset_n=1 and in_valid=0: out_q and lost_q hold their values, out_valid ← 0.
- Back-to-back in_valid:
  - Every cycle is captured and out_valid stays high continuously.
  - No backpressure and no ready signal; downstream must accept every out_valid pulse.
- Reset mid-stream: reset wins over in_valid; the captured data and valid are cleared on that edge.
- Reset values after the first reset edge: out_q=0, lost_q=0, out_valid=0. Before the first edge the registered outputs are undefined.
- No X propagation requirements beyond standard synthesis semantics; the block has no internal state other than the three registers.

Test Plan:
- Default (32/32): in=0 → out=0, lost=0. Also 26/28: in=0 → out=28'd0.
- Both instances: in=10 → out=40, lost=0. With in_valid=1, one clk later out_q=40 and out_valid=1.
- 32/32: in=32'hFFFFFFFF → out=32'hFFFFFFFC, lost=1. 26/28: in=26'h3FFFFFF → out=28'h3FFFFFC, lost=1.
- Registered hold: capture in=10, then in_valid=0 with in=5 → out_q stays 40, out_valid=0, out=20 immediately.
- Reset: reset_n=0 together with in_valid=1 and in=10 at an edge → out_q=0, lost_q=0, out_valid=0. Combinational out is still 40.
- Truncation, width_in=32, width_out=16: in=32'h0001_2345 → out=16'h8D14 (low 16 bits of 0x48D14).
